// File: rtl/fp_div_pkg.sv
// Shared types and constants for the parametrised IEEE-754 divider and its
// rounding helper.
package fp_div_pkg;

    typedef enum logic [3:0] {
        IDLE,
        UNPACK,
        SPECIAL,
        NORM_A,
        NORM_B,
        DIV_INIT,
        DIV,
        NORM,
        DENORM,
        ROUND,
        PACK,
        OUT
    } state_t;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int unsigned FLAG_NX = 0;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_NV = 4;

    // Quiet NaN with sign 0, exponent all-ones and only the fraction MSB set.
    function automatic logic [63:0] canonical_nan(input int unsigned exp_w,
                                                  input int unsigned man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fp_round_unit.sv
// Round-increment decision from sign, lsb, guard, round and sticky bits;
// unrecognised modes round to nearest-even.
module fp_round_unit
    import fp_div_pkg::*;
(
    input  logic       i_sign,
    input  logic [2:0] i_mode,
    input  logic       i_lsb,
    input  logic       i_guard,
    input  logic       i_round,
    input  logic       i_sticky,
    output logic       o_round_up_c
);

    logic w_rest;
    logic w_rne;

    assign w_rest = i_round | i_sticky;
    assign w_rne  = i_guard & (w_rest | i_lsb);

    always_comb begin
        o_round_up_c = 1'b0;
        case (i_mode)
            RM_RNE:  o_round_up_c = w_rne;
            RM_RTZ:  o_round_up_c = 1'b0;
            RM_RDN:  o_round_up_c = i_sign & (i_guard | w_rest);
            RM_RUP:  o_round_up_c = ~i_sign & (i_guard | w_rest);
            RM_RMM:  o_round_up_c = i_guard;
            default: o_round_up_c = w_rne;
        endcase
    end

endmodule

// File: rtl/fp_div_param.sv
// Multi-cycle IEEE-754 divider: restoring radix-2 mantissa division with
// subnormal handling, five rounding modes and accrued exception flags.
module fp_div_param
    import fp_div_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic [2:0]           in_rm,
    input  logic                 in_stb,
    output logic                 busy,
    output logic [EXP_W+MAN_W:0] out_z,
    output logic [4:0]           out_flags,
    output logic                 out_stb,
    input  logic                 out_busy
);

    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned MW   = MAN_W + 1;
    localparam int unsigned MW1  = MAN_W + 2;
    localparam int unsigned QW   = MAN_W + 4;
    localparam int unsigned RW   = MAN_W + 2;
    localparam int unsigned EW   = EXP_W + 3;
    localparam int unsigned CW   = $clog2(QW);
    localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
    localparam logic signed [EW-1:0] E_MIN  = E_ONE - E_BIAS;
    localparam logic [W-1:0]         QNAN   = W'(canonical_nan(EXP_W, MAN_W));

    state_t r_state, w_state_next;

    logic [W-1:0]          r_a, r_b;
    logic [2:0]            r_rm;
    logic                  r_sign;
    logic [MW-1:0]         r_ma, r_mb, r_mant;
    logic signed [EW-1:0]  r_ea, r_eb, r_e;
    logic [QW-1:0]         r_q;
    logic [RW-1:0]         r_rem;
    logic [CW-1:0]         r_cnt;
    logic                  r_sticky, r_tiny, r_inexact;
    logic                  r_busy, r_out_stb;
    logic [W-1:0]          r_out_z;
    logic [4:0]            r_out_flags;

    logic [EXP_W-1:0] w_a_exp, w_b_exp;
    logic [MAN_W-1:0] w_a_frac, w_b_frac;
    logic w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

    assign w_a_exp  = r_a[W-2:MAN_W];
    assign w_b_exp  = r_b[W-2:MAN_W];
    assign w_a_frac = r_a[MAN_W-1:0];
    assign w_b_frac = r_b[MAN_W-1:0];
    assign w_a_nan  = (&w_a_exp) & (|w_a_frac);
    assign w_b_nan  = (&w_b_exp) & (|w_b_frac);
    assign w_a_snan = w_a_nan & ~w_a_frac[MAN_W-1];
    assign w_b_snan = w_b_nan & ~w_b_frac[MAN_W-1];
    assign w_a_inf  = (&w_a_exp) & ~(|w_a_frac);
    assign w_b_inf  = (&w_b_exp) & ~(|w_b_frac);
    assign w_a_zero = ~(|w_a_exp) & ~(|w_a_frac);
    assign w_b_zero = ~(|w_b_exp) & ~(|w_b_frac);

    logic [W-1:0] w_inf, w_maxf;
    assign w_inf  = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign w_maxf = {r_sign, {{(EXP_W-1){1'b1}}, 1'b0}, {MAN_W{1'b1}}};

    // Special-operand resolution in priority order.
    logic         w_special;
    logic [W-1:0] w_spec_z;
    logic [4:0]   w_spec_flags;
    always_comb begin
        w_special    = 1'b1;
        w_spec_z     = '0;
        w_spec_flags = '0;
        if (w_a_nan | w_b_nan) begin
            w_spec_z              = QNAN;
            w_spec_flags[FLAG_NV] = w_a_snan | w_b_snan;
        end else if ((w_a_inf & w_b_inf) | (w_a_zero & w_b_zero)) begin
            w_spec_z              = QNAN;
            w_spec_flags[FLAG_NV] = 1'b1;
        end else if (w_a_inf) begin
            w_spec_z = w_inf;
        end else if (w_b_inf | w_a_zero) begin
            w_spec_z = {r_sign, {(W-1){1'b0}}};
        end else if (w_b_zero) begin
            w_spec_z              = w_inf;
            w_spec_flags[FLAG_DZ] = 1'b1;
        end else begin
            w_special = 1'b0;
        end
    end

    logic [RW-1:0] w_rem_sh;
    logic          w_div_ge;
    logic          w_denorm_shift;
    assign w_rem_sh       = {r_rem[RW-2:0], 1'b0};
    assign w_div_ge       = w_rem_sh >= RW'(r_mb);
    assign w_denorm_shift = (r_e < E_MIN) && (|r_q);

    // Quotient layout after NORM: [QW-1] integer, then fraction, guard, round, spare.
    logic           w_round_up;
    logic [MW1-1:0] w_mant_rnd;
    fp_round_unit u_round (
        .i_sign       (r_sign),
        .i_mode       (r_rm),
        .i_lsb        (r_q[3]),
        .i_guard      (r_q[2]),
        .i_round      (r_q[1]),
        .i_sticky     (r_sticky | r_q[0]),
        .o_round_up_c (w_round_up)
    );
    assign w_mant_rnd = {1'b0, r_q[QW-1:3]} + MW1'(w_round_up);

    logic             w_ovf;
    logic [EXP_W-1:0] w_exp_field;
    logic [W-1:0]     w_pack_z;
    logic [4:0]       w_pack_flags;
    assign w_ovf       = r_e > E_BIAS;
    assign w_exp_field = r_mant[MW-1] ? EXP_W'(r_e + E_BIAS) : '0;

    always_comb begin
        w_pack_z     = {r_sign, w_exp_field, r_mant[MAN_W-1:0]};
        w_pack_flags = '0;
        if (w_ovf) begin
            case (r_rm)
                RM_RTZ:  w_pack_z = w_maxf;
                RM_RDN:  w_pack_z = r_sign ? w_inf : w_maxf;
                RM_RUP:  w_pack_z = r_sign ? w_maxf : w_inf;
                default: w_pack_z = w_inf;
            endcase
            w_pack_flags[FLAG_OF] = 1'b1;
            w_pack_flags[FLAG_NX] = 1'b1;
        end else begin
            w_pack_flags[FLAG_UF] = r_tiny & r_inexact;
            w_pack_flags[FLAG_NX] = r_inexact;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (in_stb) w_state_next = UNPACK;
            UNPACK:   w_state_next = SPECIAL;
            SPECIAL:  w_state_next = w_special ? OUT : NORM_A;
            NORM_A:   if (r_ma[MW-1]) w_state_next = NORM_B;
            NORM_B:   if (r_mb[MW-1]) w_state_next = DIV_INIT;
            DIV_INIT: w_state_next = DIV;
            DIV:      if (r_cnt == CW'(1)) w_state_next = NORM;
            NORM:     w_state_next = DENORM;
            DENORM:   if (!w_denorm_shift) w_state_next = ROUND;
            ROUND:    w_state_next = PACK;
            PACK:     w_state_next = OUT;
            OUT:      if (r_out_stb && !out_busy) w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_out_stb   <= 1'b0;
            r_out_z     <= '0;
            r_out_flags <= '0;
        end else begin
            r_busy <= (w_state_next != IDLE);
            case (r_state)
                IDLE: if (in_stb) begin
                    r_a  <= in_a;
                    r_b  <= in_b;
                    r_rm <= in_rm;
                end
                UNPACK: begin
                    r_sign <= r_a[W-1] ^ r_b[W-1];
                    r_ma   <= {|w_a_exp, w_a_frac};
                    r_mb   <= {|w_b_exp, w_b_frac};
                    r_ea   <= (|w_a_exp) ? $signed({3'b000, w_a_exp}) - E_BIAS : E_MIN;
                    r_eb   <= (|w_b_exp) ? $signed({3'b000, w_b_exp}) - E_BIAS : E_MIN;
                end
                SPECIAL: if (w_special) begin
                    r_out_z     <= w_spec_z;
                    r_out_flags <= w_spec_flags;
                end
                NORM_A: if (!r_ma[MW-1]) begin
                    r_ma <= {r_ma[MW-2:0], 1'b0};
                    r_ea <= r_ea - E_ONE;
                end
                NORM_B: if (!r_mb[MW-1]) begin
                    r_mb <= {r_mb[MW-2:0], 1'b0};
                    r_eb <= r_eb - E_ONE;
                end
                DIV_INIT: begin
                    r_q      <= QW'(r_ma >= r_mb);
                    r_rem    <= (r_ma >= r_mb) ? RW'(r_ma - r_mb) : RW'(r_ma);
                    r_cnt    <= CW'(QW - 1);
                    r_e      <= r_ea - r_eb;
                    r_sticky <= 1'b0;
                    r_tiny   <= 1'b0;
                end
                DIV: begin
                    r_rem <= w_div_ge ? w_rem_sh - RW'(r_mb) : w_rem_sh;
                    r_q   <= {r_q[QW-2:0], w_div_ge};
                    r_cnt <= r_cnt - CW'(1);
                end
                NORM: begin
                    r_sticky <= |r_rem;
                    if (!r_q[QW-1]) begin
                        r_q <= {r_q[QW-2:0], 1'b0};
                        r_e <= r_e - E_ONE;
                    end
                end
                DENORM: if (w_denorm_shift) begin
                    r_q      <= {1'b0, r_q[QW-1:1]};
                    r_sticky <= r_sticky | r_q[0];
                    r_e      <= r_e + E_ONE;
                    r_tiny   <= 1'b1;
                end
                ROUND: begin
                    r_inexact <= r_q[2] | r_q[1] | r_q[0] | r_sticky;
                    if (w_mant_rnd[MW]) begin
                        r_mant <= w_mant_rnd[MW:1];
                        r_e    <= r_e + E_ONE;
                    end else begin
                        r_mant <= w_mant_rnd[MW-1:0];
                    end
                end
                PACK: begin
                    r_out_z     <= w_pack_z;
                    r_out_flags <= w_pack_flags;
                end
                OUT: begin
                    if (!r_out_stb)     r_out_stb <= 1'b1;
                    else if (!out_busy) r_out_stb <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_stb   = r_out_stb;
    assign out_z     = r_out_z;
    assign out_flags = r_out_flags;

endmodule

// File: tb/tb_fp_div_param.sv
// Directed bench for fp_div_param: fp32 and fp16 instances, hand-computed
// quotients, flags, latencies, output back-pressure and mid-operation reset.
module tb_fp_div_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_a, in_b, out_z;
    logic [2:0]  in_rm;
    logic        in_stb, busy, out_stb, out_busy;
    logic [4:0]  out_flags;

    logic [15:0] h_a, h_b, h_z;
    logic [2:0]  h_rm;
    logic        h_stb, h_busy, h_out_stb, h_out_busy;
    logic [4:0]  h_flags;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fp_div_param #(.EXP_W(8), .MAN_W(23)) u_dut (
        .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_rm(in_rm),
        .in_stb(in_stb), .busy(busy), .out_z(out_z), .out_flags(out_flags),
        .out_stb(out_stb), .out_busy(out_busy)
    );

    fp_div_param #(.EXP_W(5), .MAN_W(10)) u_dut16 (
        .clk(clk), .rst(rst), .in_a(h_a), .in_b(h_b), .in_rm(h_rm),
        .in_stb(h_stb), .busy(h_busy), .out_z(h_z), .out_flags(h_flags),
        .out_stb(h_out_stb), .out_busy(h_out_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic wait_out(input string tag, output int lat);
        bit done = 1'b0;
        lat = 0;
        while (!done && lat < 400) begin
            @(posedge clk); #1;
            lat++;
            done = out_stb;
        end
        check({tag, "_stb"}, 64'(done), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] rm, input logic [31:0] ez,
                          input logic [4:0] ef, input int elat);
        int lat;
        wait_idle(tag);
        @(negedge clk);
        in_a = a; in_b = b; in_rm = rm; in_stb = 1'b1;
        @(posedge clk); #1;
        in_stb = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        wait_out(tag, lat);
        if (elat > 0) check({tag, "_lat"}, 64'(lat), 64'(elat));
        check({tag, "_z"}, 64'(out_z), 64'(ez));
        check({tag, "_flags"}, 64'(out_flags), 64'(ef));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int spurious;
        rst = 1'b1; in_stb = 1'b0; in_a = '0; in_b = '0; in_rm = '0; out_busy = 1'b0;
        h_stb = 1'b0; h_a = '0; h_b = '0; h_rm = '0; h_out_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stb", 64'(out_stb), 64'd0);
        check("rst_z", 64'(out_z), 64'd0);
        check("rst_flags", 64'(out_flags), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // flags: NV=0x10 DZ=0x08 OF=0x04 UF=0x02 NX=0x01
        run_op("div6_2",     32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 5'h00, 36);
        run_op("third_rne",  32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 5'h01, 36);
        run_op("third_rtz",  32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 5'h01, 36);
        run_op("third_rdn",  32'h3F800000, 32'h40400000, 3'b010, 32'h3EAAAAAA, 5'h01, 36);
        run_op("third_rup",  32'h3F800000, 32'h40400000, 3'b011, 32'h3EAAAAAB, 5'h01, 36);
        run_op("third_rmm",  32'h3F800000, 32'h40400000, 3'b100, 32'h3EAAAAAB, 5'h01, 36);
        run_op("nthird_rdn", 32'hBF800000, 32'h40400000, 3'b010, 32'hBEAAAAAB, 5'h01, 36);
        run_op("nthird_rup", 32'hBF800000, 32'h40400000, 3'b011, 32'hBEAAAAAA, 5'h01, 36);

        run_op("one_div0",   32'h3F800000, 32'h00000000, 3'b000, 32'h7F800000, 5'h08, 3);
        run_op("zero_zero",  32'h00000000, 32'h00000000, 3'b000, 32'h7FC00000, 5'h10, 3);
        run_op("inf_inf",    32'h7F800000, 32'h7F800000, 3'b000, 32'h7FC00000, 5'h10, 3);
        run_op("snan",       32'h7F800001, 32'h3F800000, 3'b000, 32'h7FC00000, 5'h10, 3);
        run_op("qnan",       32'h7FC00001, 32'h3F800000, 3'b000, 32'h7FC00000, 5'h00, 3);
        run_op("inf_x",      32'h7F800000, 32'h40000000, 3'b000, 32'h7F800000, 5'h00, 3);
        run_op("x_inf",      32'hBF800000, 32'h7F800000, 3'b000, 32'h80000000, 5'h00, 3);
        run_op("zero_x",     32'h00000000, 32'hC0400000, 3'b000, 32'h80000000, 5'h00, 3);

        run_op("ovf_rne",    32'h7F7FFFFF, 32'h3E800000, 3'b000, 32'h7F800000, 5'h05, 36);
        run_op("ovf_rtz",    32'h7F7FFFFF, 32'h3E800000, 3'b001, 32'h7F7FFFFF, 5'h05, 36);
        run_op("novf_rdn",   32'hFF7FFFFF, 32'h3E800000, 3'b010, 32'hFF800000, 5'h05, 36);
        run_op("novf_rup",   32'hFF7FFFFF, 32'h3E800000, 3'b011, 32'hFF7FFFFF, 5'h05, 36);

        run_op("sub_exact",  32'h00800000, 32'h40000000, 3'b000, 32'h00400000, 5'h00, 0);
        run_op("sub_rne",    32'h00000001, 32'h40000000, 3'b000, 32'h00000000, 5'h03, 0);
        run_op("sub_rup",    32'h00000001, 32'h40000000, 3'b011, 32'h00000001, 5'h03, 0);

        // Back-pressure: result held while out_busy, stray in_stb ignored.
        wait_idle("hs");
        @(negedge clk);
        out_busy = 1'b1;
        in_a = 32'h40C00000; in_b = 32'h40000000; in_rm = 3'b000; in_stb = 1'b1;
        @(posedge clk); #1;
        in_stb = 1'b0;
        wait_out("hs_first", lat);
        check("hs_first_z", 64'(out_z), 64'h40400000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_a = 32'h3F800000; in_b = 32'h40400000; in_stb = (i % 2 == 0);
            @(posedge clk); #1;
            check("hs_hold_stb", 64'(out_stb), 64'd1);
            check("hs_hold_z", 64'(out_z), 64'h40400000);
        end
        @(negedge clk);
        out_busy = 1'b0;
        in_a = 32'h3F800000; in_b = 32'h40400000; in_rm = 3'b000; in_stb = 1'b1;
        @(posedge clk); #1;
        check("hs_drop_stb", 64'(out_stb), 64'd0);
        check("hs_drop_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        in_stb = 1'b0;
        check("hs_b2b_busy", 64'(busy), 64'd1);
        wait_out("hs_b2b", lat);
        check("hs_b2b_lat", 64'(lat), 64'd36);
        check("hs_b2b_z", 64'(out_z), 64'h3EAAAAAB);
        check("hs_b2b_flags", 64'(out_flags), 64'h01);

        // Reset in the middle of the division loop.
        wait_idle("mid_rst");
        @(negedge clk);
        in_a = 32'h40C00000; in_b = 32'h40000000; in_rm = 3'b000; in_stb = 1'b1;
        @(posedge clk); #1;
        in_stb = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_stb", 64'(out_stb), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_stb || busy) spurious++;
        end
        check("mid_rst_quiet", 64'(spurious), 64'd0);
        run_op("post_rst", 32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 5'h01, 36);

        // Half precision instance.
        @(negedge clk);
        h_a = 16'h3C00; h_b = 16'h4200; h_rm = 3'b000; h_stb = 1'b1;
        @(posedge clk); #1;
        h_stb = 1'b0;
        lat = 0;
        while (!h_out_stb && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        check("h_third_stb", 64'(h_out_stb), 64'd1);
        check("h_third_lat", 64'(lat), 64'd23);
        check("h_third_z", 64'(h_z), 64'h3555);
        check("h_third_flags", 64'(h_flags), 64'h01);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
